// File: rtl/mult_pkg.sv
// Definitions shared between the 4x4 array multiplier and its downstream accumulator.
package mult_pkg;

    localparam int PROD_W = 8;
    localparam int ACC_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned W-bit adder with carry-out reported as overflow; optionally clamps to all-ones.
module sat_add #(
    parameter int W        = 16,
    parameter int SATURATE = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = full[W];
        if (full[W] && (SATURATE != 0)) begin
            sum = '1;
        end else begin
            sum = full[W-1:0];
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive multiplier products into one wide result, presented
// on a valid/ready output and held until the consumer takes it.
module product_accumulator #(
    parameter int PROD_W   = mult_pkg::PROD_W,
    parameter int ACC_W    = mult_pkg::ACC_W,
    parameter int COUNT    = 4,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    import mult_pkg::*;

    localparam int CNT_W = $clog2(COUNT + 1);

    acc_state_t       state;
    acc_state_t       state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf;
    logic             ovf_next;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;

    assign prod_ext  = ACC_W'(in_prod);
    assign accept    = in_valid && in_ready;
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    sat_add #(
        .W        (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    // clear overrides any handshake seen in the same cycle
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_next   = prod_ext;
                        cnt_next   = CNT_W'(1);
                        ovf_next   = 1'b0;
                        state_next = (COUNT == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_next = add_sum;
                        ovf_next = ovf | add_ovf;
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt + CNT_W'(1) == CNT_W'(COUNT)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: four instances cover the default
// configuration, saturating and wrapping narrow accumulators, and COUNT=1.
module tb_product_accumulator;

    localparam int N      = 4;
    localparam int PERIOD = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         out_ready = 1'b0;
    logic [7:0]   in_prod = 8'd0;
    logic [N-1:0] in_valid = '0;
    logic [N-1:0] in_ready;
    logic [N-1:0] out_valid;
    logic [N-1:0] out_ovf;
    logic [N-1:0] busy;
    logic [15:0]  sum0;
    logic [9:0]   sum1;
    logic [9:0]   sum2;
    logic [15:0]  sum3;

    int acc_w_of [N] = '{16, 10, 10, 16};
    int sat_of   [N] = '{1, 1, 0, 1};

    typedef struct {
        int sel;
        int sum;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   stim[$];
    int   checks = 0;
    int   errors = 0;
    time  last_accept = 0;

    always #(PERIOD / 2) clk = ~clk;

    product_accumulator dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_prod(in_prod),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_sum(sum0), .out_ovf(out_ovf[0]), .busy(busy[0])
    );

    product_accumulator #(.ACC_W(10), .COUNT(5), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_prod(in_prod),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_sum(sum1), .out_ovf(out_ovf[1]), .busy(busy[1])
    );

    product_accumulator #(.ACC_W(10), .COUNT(5), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_prod(in_prod),
        .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_sum(sum2), .out_ovf(out_ovf[2]), .busy(busy[2])
    );

    product_accumulator #(.COUNT(1)) dut3 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_prod(in_prod),
        .out_valid(out_valid[3]), .out_ready(out_ready),
        .out_sum(sum3), .out_ovf(out_ovf[3]), .busy(busy[3])
    );

    function automatic logic [31:0] getSum(input int s);
        case (s)
            0:       return 32'(sum0);
            1:       return 32'(sum1);
            2:       return 32'(sum2);
            default: return 32'(sum3);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Holds in_valid until the instance accepts, bounded so a stuck DUT cannot hang the run
    task automatic sendProd(input int s, input int p);
        bit ready_seen;
        bit done;
        int stalls;
        in_prod     = 8'(p);
        in_valid[s] = 1'b1;
        done        = 1'b0;
        stalls      = 0;
        while (!done) begin
            @(negedge clk);
            ready_seen = in_ready[s];
            @(posedge clk);
            #1;
            if (ready_seen) begin
                done        = 1'b1;
                last_accept = $time - 1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    checkOutput("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        in_valid[s] = 1'b0;
    endtask

    // Drives the products in stim as one block and queues the modelled result
    task automatic applyStimulus(input int s, input int gap);
        int acc;
        int ovf;
        int max;
        exp_t e;
        acc = 0;
        ovf = 0;
        max = (1 << acc_w_of[s]) - 1;
        for (int i = 0; i < stim.size(); i++) begin
            if (i == 0) begin
                acc = stim[i];
            end else begin
                acc = acc + stim[i];
                if (acc > max) begin
                    ovf = 1;
                    acc = (sat_of[s] != 0) ? max : acc - (max + 1);
                end
            end
        end
        e.sel = s;
        e.sum = acc;
        e.ovf = ovf;
        exp_q.push_back(e);
        for (int i = 0; i < stim.size(); i++) begin
            sendProd(s, stim[i]);
            if (i != stim.size() - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        checkOutput($sformatf("latency_s%0d", s), 32'(out_valid[s]), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (out_valid[i] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_result", 32'(i), 32'd99);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput("result_sel", 32'(i), 32'(e.sel));
                        checkOutput($sformatf("out_sum_s%0d", i), getSum(i), 32'(e.sum));
                        checkOutput($sformatf("out_ovf_s%0d", i), 32'(out_ovf[i]), 32'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        #(PERIOD * 5000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        time t_first;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_sum", getSum(0), 32'd0);
        checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] four products of 225, continuous");
        out_ready = 1'b1;
        stim = '{225, 225, 225, 225};
        applyStimulus(0, 0);
        @(posedge clk);
        #1;
        checkOutput("idle_after_take_busy", 32'(busy[0]), 32'd0);
        checkOutput("idle_after_take_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("idle_after_take_sum", getSum(0), 32'd0);

        $display("[TB] gapped products, result held while out_ready low");
        out_ready = 1'b0;
        stim = '{1, 2, 3, 4};
        applyStimulus(0, 2);
        in_prod     = 8'd99;
        in_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("done_in_ready", 32'(in_ready[0]), 32'd0);
            checkOutput("done_out_valid", 32'(out_valid[0]), 32'd1);
            checkOutput("done_hold_sum", getSum(0), 32'd10);
        end
        @(posedge clk);
        #1;
        out_ready   = 1'b1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("after_take_busy", 32'(busy[0]), 32'd0);
        checkOutput("after_take_sum", getSum(0), 32'd0);
        stim = '{5, 5, 5, 5};
        applyStimulus(0, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] narrow accumulator, saturating and wrapping");
        stim = '{225, 225, 225, 225, 225};
        applyStimulus(1, 0);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(2, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] COUNT=1 result rate");
        stim = '{128};
        applyStimulus(3, 0);
        t_first = last_accept;
        applyStimulus(3, 0);
        checkOutput("count1_accept_spacing", 32'(last_accept - t_first), 32'(2 * PERIOD));
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] clear coincident with an accept");
        sendProd(0, 50);
        sendProd(0, 60);
        checkOutput("partial_sum", getSum(0), 32'd110);
        in_prod     = 8'd70;
        in_valid[0] = 1'b1;
        clear       = 1'b1;
        @(posedge clk);
        #1;
        clear       = 1'b0;
        in_valid[0] = 1'b0;
        checkOutput("clear_busy", 32'(busy[0]), 32'd0);
        checkOutput("clear_sum", getSum(0), 32'd0);
        checkOutput("clear_in_ready", 32'(in_ready[0]), 32'd1);
        stim = '{1, 1, 1, 1};
        applyStimulus(0, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] asynchronous reset mid-block");
        sendProd(0, 225);
        sendProd(0, 225);
        @(negedge clk);
        checkOutput("pre_reset_sum", getSum(0), 32'd450);
        checkOutput("pre_reset_busy", 32'(busy[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("async_rst_sum", getSum(0), 32'd0);
        checkOutput("async_rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("async_rst_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        stim = '{225, 225, 225, 225};
        applyStimulus(0, 0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
